// File: rtl/calc_pkg.sv
// Shared constants for the sequential calculator core: opcodes, FSM states and the entry radix.
package calc_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_CMP = 3'd5;
   localparam logic [2:0] OP_NOP = 3'd6;

   localparam int RADIX = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_OPSEL = 3'd1,
      ST_ENTRY = 3'd2,
      ST_EXEC  = 3'd3,
      ST_DONE  = 3'd4,
      ST_HOLD  = 3'd5
   } calc_state_t;

endpackage

// File: rtl/calc_slice_alu.sv
// Combinational W-bit ALU slice; subtract/compare invert b and rely on the caller's carry-in.
module calc_slice_alu
   import calc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   input  logic [2:0]   op,
   output logic [W-1:0] s,
   output logic         co
);

   // Slice arithmetic/logic; NOP passes a through so the committed value stays meaningful
   always_comb begin
      s  = a;
      co = 1'b0;
      case (op)
         OP_ADD:          {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
         OP_SUB, OP_CMP:  {co, s} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ci};
         OP_AND:          s = a & b;
         OP_OR:           s = a | b;
         OP_XOR:          s = a ^ b;
         default:         s = a;
      endcase
   end

endmodule

// File: rtl/calc_seq_core.sv
// Calculator control core: decimal entry, slice-serial execute, result commit.
// Optional saturation of ADD/SUB results is enabled by defining CALC_SAT_EN.
module calc_seq_core
   import calc_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int SLICE_W    = 8,
   parameter int MAX_DIGITS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       num,
   input  logic             num_valid,
   input  logic [2:0]       opt,
   input  logic             opt_valid,
   input  logic             submit,
   input  logic             clr,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] entry,
   output logic             show_entry,
   output logic             busy,
   output logic             done,
   output logic             flag_zero,
   output logic             flag_carry,
   output logic             flag_lt
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int SW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int CW     = $clog2(MAX_DIGITS + 1);
   localparam logic [WIDTH-1:0] RADIX_W    = WIDTH'(RADIX);
   localparam logic [SW-1:0]    LAST_SLICE = SW'(NSLICE - 1);
   localparam logic [CW-1:0]    MAX_CNT    = CW'(MAX_DIGITS);

   calc_state_t      state_r, state_nx_s;
   logic [WIDTH-1:0] acc_r, entry_r, last_opnd_r, res_r, commit_val_s, entry_nx_s;
   logic [CW-1:0]    cnt_r;
   logic [2:0]       op_r, pend_op_r;
   logic             pend_valid_r;
   logic [SW-1:0]    slice_r;
   logic             carry_r;
   logic             done_r, fz_r, fc_r, flt_r, show_r, busy_r;
   logic             digit_ok_s, flag_c_s, flag_lt_s, keep_acc_s;
   logic [SLICE_W-1:0] alu_a_s, alu_b_s, alu_s_s;
   logic             alu_ci_s, alu_co_s;

   assign digit_ok_s = num_valid && (num <= 4'd9);
   assign entry_nx_s = entry_r * RADIX_W + {{(WIDTH-4){1'b0}}, num};

   // Selects the active slice; subtract-type ops seed the chain with carry-in 1
   always_comb begin
      alu_a_s = acc_r[slice_r*SLICE_W +: SLICE_W];
      alu_b_s = last_opnd_r[slice_r*SLICE_W +: SLICE_W];
      if (slice_r == {SW{1'b0}}) begin
         alu_ci_s = (op_r == OP_SUB) || (op_r == OP_CMP);
      end else begin
         alu_ci_s = carry_r;
      end
   end

   calc_slice_alu #(.W(SLICE_W)) u_alu (
      .a  (alu_a_s),
      .b  (alu_b_s),
      .ci (alu_ci_s),
      .op (op_r),
      .s  (alu_s_s),
      .co (alu_co_s)
   );

   // Commit value and flags derived from the finished result and raw top carry
   always_comb begin
      commit_val_s = res_r;
      flag_c_s     = 1'b0;
      flag_lt_s    = 1'b0;
      keep_acc_s   = 1'b0;
      case (op_r)
         OP_ADD: begin
            flag_c_s = carry_r;
`ifdef CALC_SAT_EN
            if (carry_r) commit_val_s = {WIDTH{1'b1}};
            else         commit_val_s = res_r;
`else
            commit_val_s = res_r;
`endif
         end
         OP_SUB: begin
            flag_c_s = ~carry_r;
`ifdef CALC_SAT_EN
            if (!carry_r) commit_val_s = {WIDTH{1'b0}};
            else          commit_val_s = res_r;
`else
            commit_val_s = res_r;
`endif
         end
         OP_CMP: begin
            flag_c_s   = ~carry_r;
            flag_lt_s  = ~carry_r;
            keep_acc_s = 1'b1;
         end
         OP_AND, OP_OR, OP_XOR: commit_val_s = res_r;
         default: keep_acc_s = 1'b1;
      endcase
   end

   // Next-state logic; input priority opt_valid > submit > num_valid
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (opt_valid)   state_nx_s = ST_OPSEL;
            else if (submit) state_nx_s = ST_EXEC;
            else             state_nx_s = ST_IDLE;
         end
         ST_OPSEL: begin
            if (!opt_valid && digit_ok_s) state_nx_s = ST_ENTRY;
            else                          state_nx_s = ST_OPSEL;
         end
         ST_ENTRY: begin
            if (opt_valid || submit) state_nx_s = ST_EXEC;
            else                     state_nx_s = ST_ENTRY;
         end
         ST_EXEC: begin
            if (slice_r == LAST_SLICE) state_nx_s = ST_DONE;
            else                       state_nx_s = ST_EXEC;
         end
         ST_DONE: begin
            if (pend_valid_r) state_nx_s = ST_OPSEL;
            else if (submit)  state_nx_s = ST_HOLD;
            else              state_nx_s = ST_IDLE;
         end
         ST_HOLD: begin
            if (!submit) state_nx_s = ST_IDLE;
            else         state_nx_s = ST_HOLD;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register with registered display-select and busy outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         show_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else if (clr) begin
         state_r <= ST_IDLE;
         show_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         show_r  <= (state_nx_s == ST_ENTRY) || (state_nx_s == ST_EXEC);
         busy_r  <= (state_nx_s == ST_EXEC);
      end
   end

   // Datapath: operand entry, slice execution and result commit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_r <= {WIDTH{1'b0}}; entry_r <= {WIDTH{1'b0}}; last_opnd_r <= {WIDTH{1'b0}};
         res_r <= {WIDTH{1'b0}}; cnt_r <= {CW{1'b0}}; op_r <= OP_ADD; pend_op_r <= OP_ADD;
         pend_valid_r <= 1'b0; slice_r <= {SW{1'b0}}; carry_r <= 1'b0;
         done_r <= 1'b0; fz_r <= 1'b0; fc_r <= 1'b0; flt_r <= 1'b0;
      end else if (clr) begin
         acc_r <= {WIDTH{1'b0}}; entry_r <= {WIDTH{1'b0}}; last_opnd_r <= {WIDTH{1'b0}};
         res_r <= {WIDTH{1'b0}}; cnt_r <= {CW{1'b0}}; op_r <= OP_ADD; pend_op_r <= OP_ADD;
         pend_valid_r <= 1'b0; slice_r <= {SW{1'b0}}; carry_r <= 1'b0;
         done_r <= 1'b0; fz_r <= 1'b0; fc_r <= 1'b0; flt_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (opt_valid) op_r <= opt;
            end
            ST_OPSEL: begin
               if (opt_valid) begin
                  op_r <= opt;
               end else if (digit_ok_s) begin
                  entry_r <= {{(WIDTH-4){1'b0}}, num};
                  cnt_r   <= {{(CW-1){1'b0}}, 1'b1};
               end
            end
            ST_ENTRY: begin
               if (opt_valid) begin
                  pend_op_r    <= opt;
                  pend_valid_r <= 1'b1;
                  last_opnd_r  <= entry_r;
               end else if (submit) begin
                  last_opnd_r <= entry_r;
               end else if (digit_ok_s && (cnt_r < MAX_CNT)) begin
                  entry_r <= entry_nx_s;
                  cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            ST_EXEC: begin
               res_r[slice_r*SLICE_W +: SLICE_W] <= alu_s_s;
               carry_r <= alu_co_s;
               if (slice_r == LAST_SLICE) slice_r <= {SW{1'b0}};
               else                       slice_r <= slice_r + {{(SW-1){1'b0}}, 1'b1};
            end
            ST_DONE: begin
               if (!keep_acc_s) acc_r <= commit_val_s;
               fz_r    <= (commit_val_s == {WIDTH{1'b0}});
               fc_r    <= flag_c_s;
               flt_r   <= flag_lt_s;
               done_r  <= 1'b1;
               entry_r <= {WIDTH{1'b0}};
               cnt_r   <= {CW{1'b0}};
               if (pend_valid_r) begin
                  op_r         <= pend_op_r;
                  pend_valid_r <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign acc        = acc_r;
   assign entry      = entry_r;
   assign show_entry = show_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign flag_zero  = fz_r;
   assign flag_carry = fc_r;
   assign flag_lt    = flt_r;

endmodule

// File: tb/tb_calc_seq_core.sv
// Bench for calc_seq_core: directed scenarios plus randomized transactions against an arithmetic model.
module tb_calc_seq_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  num = 4'd0;
   logic        num_valid = 1'b0;
   logic [2:0]  opt = 3'd0;
   logic        opt_valid = 1'b0;
   logic        submit = 1'b0;
   logic        clr = 1'b0;
   logic [15:0] acc, entry;
   logic        show_entry, busy, done, flag_zero, flag_carry, flag_lt;

   int total = 0;
   int bad = 0;
   int model_acc = 0;

   calc_seq_core #(.WIDTH(16), .SLICE_W(8), .MAX_DIGITS(4)) dut (
      .clk(clk), .reset(reset), .num(num), .num_valid(num_valid), .opt(opt),
      .opt_valid(opt_valid), .submit(submit), .clr(clr), .acc(acc), .entry(entry),
      .show_entry(show_entry), .busy(busy), .done(done), .flag_zero(flag_zero),
      .flag_carry(flag_carry), .flag_lt(flag_lt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_digit(input logic [3:0] d);
      num = d; num_valid = 1'b1; step(); num_valid = 1'b0;
   endtask

   task automatic press_op(input logic [2:0] o);
      opt = o; opt_valid = 1'b1; step(); opt_valid = 1'b0;
   endtask

   task automatic submit_pulse();
      submit = 1'b1; step(); submit = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (done !== 1'b1) n = -1;
   endtask

   task automatic do_clr();
      clr = 1'b1; step(); clr = 1'b0;
      model_acc = 0;
   endtask

   task automatic load_acc(input int v);
      int ds[$];
      int t;
      int n;
      do_clr();
      t = v;
      if (t == 0) ds.push_back(0);
      while (t > 0) begin
         ds.push_front(t % 10);
         t = t / 10;
      end
      press_op(3'd0);
      foreach (ds[i]) press_digit(4'(ds[i]));
      submit_pulse();
      wait_done(n);
      model_acc = v;
   endtask

   task automatic test_reset();
      int n;
      int cnt;
      total++;
      if ({acc, entry, show_entry, busy, done, flag_zero, flag_carry, flag_lt} !== 38'd0) begin
         bad++; $display("FAIL reset_state: got acc=%h entry=%h flags=%b expected all zero", acc, entry, {show_entry, busy, done, flag_zero, flag_carry, flag_lt});
      end
      reset = 1'b0;
      step();
      load_acc(9);
      total++;
      if (acc !== 16'd9) begin bad++; $display("FAIL reset_preload: got %0d expected 9", acc); end
      press_op(3'd0);
      press_digit(4'd7);
      submit_pulse();
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL reset_in_exec: busy got %b expected 1", busy); end
      reset = 1'b1;
      #1;
      total++;
      if ({acc, done, flag_zero, flag_carry, flag_lt, busy} !== 21'd0) begin
         bad++; $display("FAIL reset_mid_exec: got acc=%h flags=%b expected zero", acc, {done, flag_zero, flag_carry, flag_lt, busy});
      end
      step();
      reset = 1'b0;
      model_acc = 0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (done === 1'b1) cnt++;
      end
      total++;
      if (cnt !== 0 || acc !== 16'd0 || busy !== 1'b0 || show_entry !== 1'b0) begin
         bad++; $display("FAIL reset_abort: got dones=%0d acc=%h busy=%b show=%b expected 0 0 0 0", cnt, acc, busy, show_entry);
      end
      submit_pulse();
      wait_done(n);
      total++;
      if (n !== 3 || acc !== 16'd0) begin bad++; $display("FAIL reset_idle_repeat: got lat=%0d acc=%h expected 3 0", n, acc); end
   endtask

   task automatic test_add();
      int n;
      do_clr();
      press_op(3'd0);
      press_digit(4'd1); press_digit(4'd2); press_digit(4'd3);
      total++;
      if (entry !== 16'd123 || show_entry !== 1'b1) begin bad++; $display("FAIL add_entry: got %0d show=%b expected 123 1", entry, show_entry); end
      submit_pulse();
      wait_done(n);
      total++;
      if (n !== 3) begin bad++; $display("FAIL add_latency: got %0d expected 3", n); end
      total++;
      if (acc !== 16'd123 || flag_zero !== 1'b0 || flag_carry !== 1'b0) begin
         bad++; $display("FAIL add_result: got acc=%0d z=%b c=%b expected 123 0 0", acc, flag_zero, flag_carry);
      end
   endtask

   task automatic test_sub_borrow();
      int n;
      logic [15:0] exp_acc;
      logic        exp_z;
`ifdef CALC_SAT_EN
      exp_acc = 16'h0000; exp_z = 1'b1;
`else
      exp_acc = 16'hFFFE; exp_z = 1'b0;
`endif
      load_acc(5);
      press_op(3'd1);
      press_digit(4'd7);
      submit_pulse();
      wait_done(n);
      total++;
      if (acc !== exp_acc || flag_carry !== 1'b1 || flag_zero !== exp_z) begin
         bad++; $display("FAIL sub_borrow: got acc=%h c=%b z=%b expected %h 1 %b", acc, flag_carry, flag_zero, exp_acc, exp_z);
      end
   endtask

   task automatic test_chain_cmp();
      int n;
      load_acc(40);
      press_op(3'd0);
      press_digit(4'd2);
      press_op(3'd5);
      wait_done(n);
      total++;
      if (n !== 3 || acc !== 16'd42) begin bad++; $display("FAIL chain_commit: got lat=%0d acc=%0d expected 3 42", n, acc); end
      step();
      total++;
      if (busy !== 1'b0 || show_entry !== 1'b0) begin bad++; $display("FAIL chain_opsel: got busy=%b show=%b expected 0 0", busy, show_entry); end
      press_digit(4'd5); press_digit(4'd0);
      total++;
      if (entry !== 16'd50) begin bad++; $display("FAIL chain_entry: got %0d expected 50", entry); end
      submit_pulse();
      wait_done(n);
      total++;
      if (acc !== 16'd42 || flag_lt !== 1'b1 || flag_carry !== 1'b1) begin
         bad++; $display("FAIL cmp_result: got acc=%0d lt=%b c=%b expected 42 1 1", acc, flag_lt, flag_carry);
      end
      model_acc = 42;
   endtask

   task automatic test_digit_cap_repeat();
      int n;
      int cnt;
      do_clr();
      press_op(3'd0);
      for (int d = 1; d <= 5; d++) press_digit(4'(d));
      total++;
      if (entry !== 16'd1234) begin bad++; $display("FAIL digit_cap: got %0d expected 1234", entry); end
      submit = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (done === 1'b1) cnt++;
      end
      submit = 1'b0;
      total++;
      if (cnt !== 1 || acc !== 16'd1234) begin bad++; $display("FAIL held_submit: got dones=%0d acc=%0d expected 1 1234", cnt, acc); end
      step(); step();
      submit_pulse();
      wait_done(n);
      total++;
      if (n !== 3 || acc !== 16'd2468) begin bad++; $display("FAIL repeat: got lat=%0d acc=%0d expected 3 2468", n, acc); end
      model_acc = 2468;
   endtask

   task automatic test_boundaries();
      int n;
      do_clr();
      press_op(3'd0);
      press_digit(4'd3);
      press_digit(4'd11);
      total++;
      if (entry !== 16'd3) begin bad++; $display("FAIL invalid_digit: got %0d expected 3", entry); end
      num = 4'd4; num_valid = 1'b1; opt = 3'd0; opt_valid = 1'b1;
      step();
      num_valid = 1'b0; opt_valid = 1'b0;
      wait_done(n);
      total++;
      if (n !== 3 || acc !== 16'd3 || entry !== 16'd0) begin
         bad++; $display("FAIL opt_beats_digit: got lat=%0d acc=%0d entry=%0d expected 3 3 0", n, acc, entry);
      end
      step();
      press_digit(4'd9);
      total++;
      if (entry !== 16'd9 || show_entry !== 1'b1) begin bad++; $display("FAIL chained_entry: got %0d show=%b expected 9 1", entry, show_entry); end
      do_clr();
      total++;
      if (entry !== 16'd0 || show_entry !== 1'b0 || acc !== 16'd0) begin
         bad++; $display("FAIL clr_entry: got entry=%0d show=%b acc=%0d expected 0 0 0", entry, show_entry, acc);
      end
   endtask

   task automatic test_random();
      int n, op, ndig, opnd, cnt, a, r, d;
      logic exp_c, exp_lt, chk_z;
      do_clr();
      for (int it = 0; it < 30; it++) begin
         op = $urandom_range(7, 0);
         ndig = $urandom_range(6, 1);
         press_op(3'(op));
         opnd = 0; cnt = 0;
         for (int k = 0; k < ndig; k++) begin
            d = (k > 0 && $urandom_range(4, 0) == 0) ? $urandom_range(15, 10) : $urandom_range(9, 0);
            press_digit(4'(d));
            if (d <= 9 && cnt < 4) begin
               opnd = opnd * 10 + d;
               cnt++;
            end
         end
         total++;
         if (entry !== 16'(opnd)) begin bad++; $display("FAIL rand_entry[%0d]: got %0d expected %0d", it, entry, opnd); end
         a = model_acc; r = a; exp_c = 1'b0; exp_lt = 1'b0; chk_z = 1'b1;
         case (op)
            0: begin
               exp_c = (a + opnd) > 65535; r = (a + opnd) & 'hFFFF;
`ifdef CALC_SAT_EN
               if (exp_c) r = 'hFFFF;
`endif
            end
            1: begin
               exp_c = a < opnd; r = (a - opnd) & 'hFFFF;
`ifdef CALC_SAT_EN
               if (exp_c) r = 0;
`endif
            end
            2: r = a & opnd;
            3: r = a | opnd;
            4: r = a ^ opnd;
            5: begin exp_c = a < opnd; exp_lt = exp_c; chk_z = 1'b0; end
            default: chk_z = 1'b0;
         endcase
         submit_pulse();
         wait_done(n);
         model_acc = r;
         total++;
         if (n !== 3 || acc !== 16'(r) || flag_carry !== exp_c || flag_lt !== exp_lt) begin
            bad++; $display("FAIL rand_exec[%0d] op=%0d: got lat=%0d acc=%h c=%b lt=%b expected 3 %h %b %b", it, op, n, acc, flag_carry, flag_lt, 16'(r), exp_c, exp_lt);
         end
         if (chk_z) begin
            total++;
            if (flag_zero !== (r == 0)) begin bad++; $display("FAIL rand_zero[%0d]: got %b expected %b", it, flag_zero, (r == 0)); end
         end
      end
   endtask

   initial begin
      step(); step();
      test_reset();
      test_add();
      test_sub_borrow();
      test_chain_cmp();
      test_digit_cap_repeat();
      test_boundaries();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
